// File: rtl/usb_pkg.sv
// Shared line-state codes, FSM encoding and protocol constants for the USB receive path.
// Pure definitions: no latency, no backpressure.
package usb_pkg;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_DATA      = 3'd2,
        ST_EOP       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam logic [2:0] SYNC_ZEROS  = 3'd7;
    localparam logic [2:0] STUFF_RUN   = 3'd6;
    localparam logic [1:0] EOP_MIN_SE0 = 2'd2;

    typedef struct packed {
        logic data;
        logic val;
        logic active;
        logic eop;
        logic err;
    } rx_out_t;

    function automatic logic is_jk(input logic [1:0] ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

// File: rtl/usb_receiver_if.sv
// Pad pins in, decoded bit stream and packet strobes out.
// Stream has no backpressure: the consumer must take every s_data_val cycle.
interface usb_receiver_if;
    logic d_plus;
    logic d_minus;
    logic s_data_out;
    logic s_data_val;
    logic rx_active;
    logic rx_eop;
    logic rx_err;

    modport master (
        input  d_plus, d_minus,
        output s_data_out, s_data_val, rx_active, rx_eop, rx_err
    );

    modport slave (
        output d_plus, d_minus,
        input  s_data_out, s_data_val, rx_active, rx_eop, rx_err
    );
endinterface

// File: rtl/usb_line_decoder.sv
// Pin register plus previous sample; exposes the current line state and its NRZI bit.
// One cycle from pins to line_state/nrzi_bit; no backpressure.
module usb_line_decoder
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [1:0] line_state,
    output logic       nrzi_bit
);

    logic [1:0] line_q;
    logic [1:0] line_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= LS_J;
            line_p <= LS_J;
        end else begin
            line_q <= {d_plus, d_minus};
            line_p <= line_q;
        end
    end

    // No level change means a 1; only meaningful when line_state is J or K.
    assign line_state = line_q;
    assign nrzi_bit   = (line_q == line_p);

endmodule

// File: rtl/usb_receiver.sv
// USB serial receiver: SYNC lock, optional unstuffing, EOP/error detection, serial bit output.
// Pins to outputs in 2 cycles; no backpressure, every s_data_val must be consumed.
module usb_receiver
    import usb_pkg::*;
#(
    parameter bit STUFF_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_receiver_if.master        bus
);

    logic [1:0] line_state;
    logic       nrzi_bit;

    usb_line_decoder u_line_decoder (
        .clk        (clk),
        .rst        (rst),
        .d_plus     (bus.d_plus),
        .d_minus    (bus.d_minus),
        .line_state (line_state),
        .nrzi_bit   (nrzi_bit)
    );

    rx_state_t  state;
    logic [2:0] zero_cnt;
    logic [2:0] ones_cnt;
    logic [1:0] se0_cnt;
    rx_out_t    out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            zero_cnt <= 3'd0;
            ones_cnt <= 3'd0;
            se0_cnt  <= 2'd0;
            out_q    <= '0;
        end else begin
            out_q.data <= 1'b0;
            out_q.val  <= 1'b0;
            out_q.eop  <= 1'b0;
            out_q.err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A K right after J is the first SYNC bit.
                    if (line_state == LS_K && !nrzi_bit) begin
                        state    <= ST_SYNC;
                        zero_cnt <= 3'd1;
                    end
                end

                ST_SYNC: begin
                    if (is_jk(line_state) && !nrzi_bit && zero_cnt < SYNC_ZEROS) begin
                        zero_cnt <= zero_cnt + 3'd1;
                    end else if (is_jk(line_state) && nrzi_bit && zero_cnt == SYNC_ZEROS) begin
                        state        <= ST_DATA;
                        ones_cnt     <= 3'd0;
                        out_q.active <= 1'b1;
                    end else begin
                        state     <= ST_WAIT_IDLE;
                        out_q.err <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (is_jk(line_state)) begin
                        if (STUFF_EN && ones_cnt == STUFF_RUN) begin
                            // The bit after a full run of ones is a stuffed 0 and is dropped.
                            if (nrzi_bit) begin
                                state        <= ST_WAIT_IDLE;
                                out_q.err    <= 1'b1;
                                out_q.active <= 1'b0;
                            end else begin
                                ones_cnt <= 3'd0;
                            end
                        end else begin
                            out_q.data <= nrzi_bit;
                            out_q.val  <= 1'b1;
                            if (STUFF_EN) begin
                                ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            end
                        end
                    end else if (line_state == LS_SE0) begin
                        state   <= ST_EOP;
                        se0_cnt <= 2'd1;
                    end else begin
                        state        <= ST_WAIT_IDLE;
                        out_q.err    <= 1'b1;
                        out_q.active <= 1'b0;
                    end
                end

                ST_EOP: begin
                    case (line_state)
                        LS_SE0: begin
                            if (se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
                        end
                        LS_J: begin
                            out_q.active <= 1'b0;
                            if (se0_cnt >= EOP_MIN_SE0) begin
                                state     <= ST_IDLE;
                                out_q.eop <= 1'b1;
                            end else begin
                                state     <= ST_WAIT_IDLE;
                                out_q.err <= 1'b1;
                            end
                        end
                        default: begin
                            state        <= ST_WAIT_IDLE;
                            out_q.err    <= 1'b1;
                            out_q.active <= 1'b0;
                        end
                    endcase
                end

                ST_WAIT_IDLE: begin
                    if (line_state == LS_J) state <= ST_IDLE;
                end

                default: begin
                    state        <= ST_IDLE;
                    out_q.active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_data_out = out_q.data;
    assign bus.s_data_val = out_q.val;
    assign bus.rx_active  = out_q.active;
    assign bus.rx_eop     = out_q.eop;
    assign bus.rx_err     = out_q.err;

endmodule

// File: doc/usb_receiver.md
# usb_receiver

Serial USB high-speed-polarity line receiver. Samples `d_plus`/`d_minus` once per `clk`, classifies the line state, NRZI-decodes, locks onto SYNC, optionally removes stuffed bits, and delivers a serial bit stream with valid, plus end-of-packet and error strobes. It is the receive-side counterpart of the hub's serial transmitter and sits between the pad interface and the packet deframer.

## Interface
- `STUFF_EN`, default 0: 1 enables bit unstuffing and stuff-error checking; 0 passes every decoded bit through.
- `clk`  in  1  sole clock; one line sample per cycle (one bit time = one cycle).
- `rst`  in  1  synchronous, active-high reset.
- `d_plus`  in  1  line D+.
- `d_minus`  in  1  line D-.
- `s_data_out`  out  1  decoded data bit, LSB-first as sent.
- `s_data_val`  out  1  `s_data_out` is a valid payload bit this cycle.
- `rx_active`  out  1  high while a packet is between SYNC and EOP.
- `rx_eop`  out  1  one-cycle pulse on valid EOP.
- `rx_err`  out  1  one-cycle pulse on any protocol error.

## Operation
- Line states, as {d_plus,d_minus}:
  - J = 10, also idle.
  - K = 01.
  - SE0 = 00.
  - SE1 = 11, always illegal.
- Stage 1 registers the pins into `line_q`; `line_p` holds the previous `line_q`.
- NRZI: for J/K samples, bit = 1 if `line_q == line_p`, else 0.
- FSM states and transitions:
  - IDLE: on K following J, go to SYNC. This first K is SYNC bit 0; the zero count starts at 1.
  - SYNC: expects decoded 0s until seven zeros total, then a 1 (line K J K J K J K K); on that 1, go to DATA with `rx_active` asserted. Any other bit, SE0 or SE1: pulse `rx_err`, go to WAIT_IDLE.
  - DATA: each J/K sample outputs its bit with `s_data_val`=1. SE0: go to EOP with `s_data_val`=0. SE1: `rx_err`, go to WAIT_IDLE.
  - Unstuffing (STUFF_EN=1 only): a 3-bit ones counter counts consecutive 1s and clears on 0. After six 1s the next bit must be 0 and is dropped (no `s_data_val`). If that bit is 1, pulse `rx_err` and go to WAIT_IDLE.
  - EOP: a saturating SE0 counter (2 bits) is 1 on entry.
    - Further SE0 samples increment it.
    - J with count ≥ 2: pulse `rx_eop`, go to IDLE.
    - J with count 1, K, or SE1: pulse `rx_err`, go to WAIT_IDLE.
  - WAIT_IDLE: leave for IDLE on the first J sample; all data outputs stay low.
- `rx_eop` and `rx_err` are never asserted in the same cycle.
- `rx_active` deasserts in the same cycle as the `rx_eop` or `rx_err` pulse.
- Reset mid-packet abandons the packet silently: no `rx_err`, no `rx_eop`.

## Timing
- Reset values:
  - Outputs: `s_data_out`=0, `s_data_val`=0, `rx_active`=0, `rx_eop`=0, `rx_err`=0.
  - State: FSM=IDLE, `line_q`=`line_p`=J, all counters 0.
- Latency: a pin value present before edge n is registered at n; its decoded output is valid after edge n+1. Pin-to-output latency is 2 cycles, for data, strobes and `rx_active` alike.
- `rx_active` rises together with the first cycle after the SYNC-terminating bit is decoded.
- There is no backpressure: the consumer must accept every `s_data_val` cycle.
- SE0 runs of 3 or more cycles are accepted; the counter saturates at 3.
- A K straight after EOP's J is handled in IDLE and may start a new SYNC with no gap.

## Structure
- Package `usb_pkg` holds:
  - line-state constants J/K/SE0/SE1 (2-bit);
  - FSM state encoding (3-bit: IDLE, SYNC, DATA, EOP, WAIT_IDLE);
  - `SYNC_ZEROS`=7;
  - `STUFF_RUN`=6;
  - `EOP_MIN_SE0`=2.
- One sub-module, `usb_line_decoder`, holds the pin register, `line_p`, the line-state classification and the NRZI bit. Its outputs are `line_state` and `nrzi_bit`.
- The FSM, counters and output registers live in `usb_receiver`.

## Test plan
- Reset: hold `rst` for 3 cycles while driving K/SE0 on the pins → all outputs 0; FSM reaches IDLE after `rst` falls with J present.
- Basic packet, STUFF_EN=0: idle J, SYNC, byte 0xA5 LSB-first, SE0, SE0, J → eight `s_data_val` bits 1,0,1,0,0,1,0,1. `rx_active` is high across them. `rx_eop` pulses once, 2 cycles after the J is driven. No `rx_err`.
- Bad SYNC: K J K J K K → `rx_err` pulse, no `s_data_val`, no `rx_active`. The next clean packet is received correctly.
- Unstuffing, STUFF_EN=1:
  - Payload 1111110 1: seven 1s are output and the stuffed 0 is dropped.
  - Payload 1111111: `rx_err` pulses on the seventh 1 and WAIT_IDLE is entered.
- Line errors:
  - SE1 mid-DATA → `rx_err`.
  - Single SE0 then J → `rx_err`, no `rx_eop`.
  - SE0 ×3 then J → `rx_eop`.
- Reset mid-packet: assert `rst` after 4 data bits → all outputs 0 the next cycle, no strobes. A following packet decodes correctly.
